uart_rx: RTL and testbench

UART receiver that deserialises 8N1 frames from the PC on the `rx` pin and presents each received byte as a single-cycle valid/data pulse. It is the PC-to-FPGA counterpart of `uart_tx` and runs in the same 50 MHz domain. It shares the `axiov`/`axiod` naming and the baud-rate parameters, so one design can loop bytes between the two blocks. There is no backpressure: the consumer must capture each byte on the cycle it is valid.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and baud divisor helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Integer-truncated clock cycles per serial bit.
    function automatic int cycles_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous levels into the clk domain.
module sync_2ff #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronised line, one-cycle byte and
// framing-error pulses, and a BREAK state so a held-low line cannot retrigger frames.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 axiov,
    output logic [DATA_BITS-1:0] axiod,
    output logic                 framing_err,
    output logic                 busy
);

    localparam int CPB  = cycles_per_bit(CLK_HZ, BAUD);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int IW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_BIT_END  = CW'(CPB - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(DATA_BITS - 1);

    if (CPB < 4) begin : g_cpb_check
        $error("uart_rx: CLK_HZ/BAUD must be at least 4");
    end

    logic                 rx_s;
    rx_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] axiod_n;
    logic                 axiov_n, framing_err_n;

    sync_2ff #(
        .WIDTH    (1),
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx),
        .q    (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            axiod       <= '0;
            axiov       <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            shreg       <= shreg_n;
            axiod       <= axiod_n;
            axiov       <= axiov_n;
            framing_err <= framing_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        cnt_n         = cnt + 1'b1;
        bit_idx_n     = bit_idx;
        shreg_n       = shreg;
        axiod_n       = axiod;
        axiov_n       = 1'b0;
        framing_err_n = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                // Re-check the line half a bit in so short glitches are discarded.
                if (cnt == CNT_HALF_END) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == CNT_BIT_END) begin
                    cnt_n     = '0;
                    shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == IDX_LAST) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_BIT_END) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        axiod_n = shreg;
                        axiov_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        framing_err_n = 1'b1;
                        state_n       = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial driver pushes expected bytes/errors and arrival
// cycles into queues, a negedge monitor pops and compares each output pulse.
module tb_uart_rx;

    localparam int CPB  = 434;
    localparam int HALF = 217;
    // Pin fall to axiov: 2 sync cycles to t0, then HALF + 9*CPB to the stop sample, +1 register.
    localparam int LAT  = HALF + 9 * CPB + 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       axiov;
    logic [7:0] axiod;
    logic       framing_err;
    logic       busy;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    int         t_q[$];
    logic [7:0] last_good = 8'h00;
    logic       prev_v = 1'b0;
    logic [8:0] mon_e;
    int         mon_t;

    uart_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .axiov      (axiov),
        .axiod      (axiod),
        .framing_err(framing_err),
        .busy       (busy)
    );

    // Clock / reset block
    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Driver: must be called on a negedge; returns on the negedge ending the stop bit.
    task automatic send_byte(input logic [7:0] d, input int bitc, input logic stop_bit,
                             input bit timed);
        rx = 1'b0;
        if (stop_bit) begin
            exp_q.push_back({1'b0, d});
            last_good = d;
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
        t_q.push_back(timed ? cyc + LAT : -1);
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (bitc) @(negedge clk);
        end
        rx = stop_bit;
        repeat (bitc) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        t_q.delete();
        repeat (10) @(negedge clk);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && (axiov || framing_err)) begin
            chk("exclusive", {31'b0, axiov & framing_err}, 0);
            if (axiov) chk("axiov_width", {31'b0, prev_v}, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: axiov=%0b framing_err=%0b axiod=%0h (cycle %0d)",
                         axiov, framing_err, axiod, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = t_q.pop_front();
                chk("pulse_kind", {31'b0, framing_err}, {31'b0, mon_e[8]});
                chk("axiod", {24'b0, axiod}, {24'b0, mon_e[7:0]});
                if (mon_t >= 0) chk("latency", cyc, mon_t);
            end
        end
        prev_v <= axiov;
    end

    // Stimulus
    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_axiov", {31'b0, axiov}, 0);
        chk("reset_ferr", {31'b0, framing_err}, 0);
        chk("reset_busy", {31'b0, busy}, 0);
        chk("reset_axiod", {24'b0, axiod}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte
        send_byte(8'hA5, CPB, 1'b1, 1'b1);
        drain(6000);
        chk("single_busy_low", {31'b0, busy}, 0);

        // Back-to-back, no idle gap: exact latency per frame implies 10*CPB spacing
        send_byte(8'h00, CPB, 1'b1, 1'b1);
        send_byte(8'hFF, CPB, 1'b1, 1'b1);
        send_byte(8'h55, CPB, 1'b1, 1'b1);
        drain(6000);
        chk("b2b_busy_low", {31'b0, busy}, 0);

        // Glitch: 100-cycle low pulse
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (HALF + 2 - 100) @(negedge clk);
        chk("glitch_busy_at_sample", {31'b0, busy}, 1);
        @(negedge clk);
        chk("glitch_back_idle", {31'b0, busy}, 0);
        repeat (50) @(negedge clk);

        // Framing error then line held low, then a good frame
        send_byte(8'h3C, CPB, 1'b0, 1'b1);
        repeat (5000) @(negedge clk);
        chk("ferr_consumed", exp_q.size(), 0);
        chk("break_busy", {31'b0, busy}, 1);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("break_exit", {31'b0, busy}, 0);
        send_byte(8'h81, CPB, 1'b1, 1'b1);
        drain(6000);

        // Reset during data bit 4 of 8'hF0
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b0;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_axiov", {31'b0, axiov}, 0);
        chk("midrst_ferr", {31'b0, framing_err}, 0);
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_axiod", {24'b0, axiod}, 0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        last_good = 8'h00;
        repeat (5 * CPB) @(negedge clk);
        chk("post_reset_idle", {31'b0, busy}, 0);
        chk("post_reset_axiod", {24'b0, axiod}, 0);
        send_byte(8'h12, CPB, 1'b1, 1'b1);
        drain(6000);

        // Baud skew: +2% (425 cycles/bit) and -2% (443 cycles/bit)
        send_byte(8'hC3, 425, 1'b1, 1'b0);
        drain(6000);
        send_byte(8'hC3, 443, 1'b1, 1'b0);
        drain(6000);
        chk("final_busy_low", {31'b0, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
